tff_toggle_arbiter: RTL

//   Round-robin controller that shares one toggle flip-flop (flipflopT) among

---
 rtl/tff_toggle_arbiter.sv | 107 ++++++++++
 1 files changed

// File: rtl/tff_toggle_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tff_toggle_arbiter
// Brief   : Round-robin owner of a shared toggle flip-flop enable; the winner
//           gets exactly cnt[i] enable cycles, then a done pulse.
// Revision: 1.0 - initial release
// ============================================================================
module tff_toggle_arbiter #(
    parameter int NREQ = 4,
    parameter int CNTW = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*CNTW-1:0] cnt,
    output logic [NREQ-1:0]      gnt,
    output logic                 t_en,
    output logic                 busy,
    output logic                 done,
    output logic [2:0]           owner
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]      r_state;
    logic [2:0]      r_ptr;
    logic [CNTW-1:0] r_rem;

    logic            w_found;
    logic [2:0]      w_idx;
    logic [CNTW-1:0] w_cnt_sel;
    logic [NREQ-1:0] w_onehot;

    // Scan from ptr+1 with wrap; descending loop leaves the nearest hit last.
    always_comb begin
        w_found = 1'b0;
        w_idx   = '0;
        for (int k = NREQ; k >= 1; k--) begin
            if (req[(int'(r_ptr) + k) % NREQ]) begin
                w_found = 1'b1;
                w_idx   = 3'((int'(r_ptr) + k) % NREQ);
            end
        end
    end

    assign w_cnt_sel = cnt[int'(w_idx)*CNTW +: CNTW];
    assign w_onehot  = NREQ'(1) << w_idx;

    // DONE spends one settle cycle with t_en low before done rises, then one
    // cycle with done high; gnt and busy cover both.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_IDLE;
            r_ptr   <= 3'(NREQ - 1);
            r_rem   <= '0;
            gnt     <= '0;
            t_en    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            owner   <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_found) begin
                        gnt   <= w_onehot;
                        owner <= w_idx;
                        r_ptr <= w_idx;
                        r_rem <= w_cnt_sel;
                        busy  <= 1'b1;
                        if (w_cnt_sel != '0) begin
                            t_en    <= 1'b1;
                            r_state <= c_RUN;
                        end else begin
                            r_state <= c_DONE;
                        end
                    end
                end
                c_RUN: begin
                    if (r_rem <= CNTW'(1)) begin
                        t_en    <= 1'b0;
                        r_rem   <= '0;
                        r_state <= c_DONE;
                    end else begin
                        r_rem <= r_rem - CNTW'(1);
                    end
                end
                c_DONE: begin
                    if (!done) begin
                        done <= 1'b1;
                    end else begin
                        done    <= 1'b0;
                        gnt     <= '0;
                        busy    <= 1'b0;
                        r_state <= c_IDLE;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
